// File: rtl/pbit_field_accumulator.sv
// Serial local-field accumulator feeding a p-bit cell: one neighbour per clock,
// quantised to {activation[3:0], shift[1:0]}. Optional macro PBIT_FIELD_SAT_EN adds sat_count.
module pbit_field_accumulator #(
  parameter int N_NEIGH   = 8,
  parameter int W_WIDTH   = 6,
  parameter int ACC_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_we,
  input  logic [$clog2(N_NEIGH)-1:0] w_addr,
  input  logic [W_WIDTH-1:0]         w_data,
  input  logic                       bias_we,
  input  logic [W_WIDTH-1:0]         bias_data,
  input  logic                       beta_we,
  input  logic [1:0]                 beta_data,
  input  logic [N_NEIGH-1:0]         spins,
  input  logic                       start,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 out_word
`ifdef PBIT_FIELD_SAT_EN
  ,
  output logic [7:0]                 sat_count
`endif
);

  // state | meaning
  // IDLE  | waiting for start, out_word held
  // ACCUM | adding +/- w[idx] for one neighbour per edge
  // QUANT | clamp acc+8 to 0..15 and register out_word
  // HOLD  | out_valid high until out_ready
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] QUANT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int IDX_W = $clog2(N_NEIGH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEIGH - 1);

  logic [1:0]               state;
  logic [W_WIDTH-1:0]       weight [N_NEIGH];
  logic [W_WIDTH-1:0]       bias_reg;
  logic [1:0]               beta_reg;
  logic [1:0]               beta_snap;
  logic [N_NEIGH-1:0]       snap;
  logic [ACC_WIDTH-1:0]     acc;
  logic [IDX_W-1:0]         idx;

  logic [W_WIDTH-1:0]       w_cur;
  logic [ACC_WIDTH-1:0]     w_ext;
  logic [ACC_WIDTH-1:0]     bias_ext;
  logic [ACC_WIDTH-1:0]     t;
  logic                     sat_lo;
  logic                     sat_hi;
  logic [3:0]               activation;

  always_comb begin
    w_cur    = weight[idx];
    w_ext    = {{(ACC_WIDTH-W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};
    bias_ext = {{(ACC_WIDTH-W_WIDTH){bias_reg[W_WIDTH-1]}}, bias_reg};
    t        = acc + ACC_WIDTH'(8);
    sat_lo   = t[ACC_WIDTH-1];
    sat_hi   = !sat_lo && (|t[ACC_WIDTH-2:4]);
    if (sat_lo)
      activation = 4'h0;
    else if (sat_hi)
      activation = 4'hF;
    else
      activation = t[3:0];
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

  // Configuration: writes land in any state; the accumulate path reads the
  // pre-edge weight, so a same-edge write to the active idx is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEIGH; i++)
        weight[i] <= '0;
      bias_reg <= '0;
      beta_reg <= '0;
    end else begin
      if (w_we)
        weight[w_addr] <= w_data;
      if (bias_we)
        bias_reg <= bias_data;
      if (beta_we)
        beta_reg <= beta_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      snap      <= '0;
      beta_snap <= '0;
      acc       <= '0;
      idx       <= '0;
      out_word  <= 6'b100000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap      <= spins;
            beta_snap <= beta_reg;
            acc       <= bias_ext;
            idx       <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= snap[idx] ? (acc + w_ext) : (acc - w_ext);
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= QUANT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        QUANT: begin
          out_word <= {activation, beta_snap};
          state    <= HOLD;
        end
        HOLD: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PBIT_FIELD_SAT_EN
  always_ff @(posedge clk) begin
    if (reset)
      sat_count <= '0;
    else if ((state == QUANT) && (sat_lo || sat_hi) && (sat_count != 8'hFF))
      sat_count <= sat_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pbit_field_accumulator.sv
// Directed self-checking bench for pbit_field_accumulator (N_NEIGH=8, W_WIDTH=6).
// Tracks sat_count expectations when built with PBIT_FIELD_SAT_EN.
module tb_pbit_field_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       w_we;
  logic [2:0] w_addr;
  logic [5:0] w_data;
  logic       bias_we;
  logic [5:0] bias_data;
  logic       beta_we;
  logic [1:0] beta_data;
  logic [7:0] spins;
  logic       start;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_word;
`ifdef PBIT_FIELD_SAT_EN
  logic [7:0] sat_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int exp_sat  = 0;

  always #5 clk = ~clk;

  pbit_field_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .bias_we   (bias_we),
    .bias_data (bias_data),
    .beta_we   (beta_we),
    .beta_data (beta_data),
    .spins     (spins),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word)
`ifdef PBIT_FIELD_SAT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sat(input string tag);
`ifdef PBIT_FIELD_SAT_EN
    check(tag, {24'd0, sat_count}, exp_sat);
`else
    if (exp_sat < 0) $display("unreachable %s", tag);
`endif
  endtask

  // All weights get wv; bias and beta are written on the same edge as w[0].
  task automatic set_all(input logic [5:0] wv, input logic [5:0] bv, input logic [1:0] be);
    for (int i = 0; i < 8; i++) begin
      w_we = 1'b1; w_addr = 3'(i); w_data = wv;
      bias_we = (i == 0); bias_data = bv;
      beta_we = (i == 0); beta_data = be;
      tick();
    end
    w_we = 1'b0; bias_we = 1'b0; beta_we = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] sp);
    spins = sp;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    check("busy_after_start", {31'd0, busy}, 1);
  endtask

  task automatic wait_result(input string tag, input logic [5:0] exp_word);
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_word"}, {26'd0, out_word}, {26'd0, exp_word});
    check_sat({tag, "_sat"});
  endtask

  task automatic accept(input string tag, input logic [5:0] exp_word);
    out_ready = 1'b1;
    tick();
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 0);
    check({tag, "_busy_drop"}, {31'd0, busy}, 0);
    check({tag, "_word_held"}, {26'd0, out_word}, {26'd0, exp_word});
  endtask

  initial begin
    reset = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
    bias_we = 1'b0; bias_data = '0; beta_we = 1'b0; beta_data = '0;
    spins = '0; start = 1'b0; out_ready = 1'b1;

    // Reset for two cycles
    tick(); tick();
    reset = 1'b0;
    check("rst_word", {26'd0, out_word}, 32'h20);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check_sat("rst_sat");

    // Positive saturation: acc = 24, t = 32 -> 15
    set_all(6'd3, 6'd0, 2'b00);
    start_run(8'hFF);
    exp_sat = 1;
    wait_result("possat", 6'h3C);
    accept("possat", 6'h3C);

    // Mid-range: acc = 2 + 4 - 4 = 2, t = 10
    set_all(6'd1, 6'd2, 2'b01);
    start_run(8'h0F);
    wait_result("mid", 6'h29);
    accept("mid", 6'h29);

    // Same-edge weight write at active idx uses old weight; bias write mid-run ignored
    set_all(6'd1, 6'd0, 2'b00);
    start_run(8'hFF);
    w_we = 1'b1; w_addr = 3'd0; w_data = 6'h38;
    bias_we = 1'b1; bias_data = 6'd31;
    tick(); cyc++;
    w_we = 1'b0; bias_we = 1'b0;
    exp_sat = 2;
    wait_result("collide", 6'h3C);
    accept("collide", 6'h3C);
    bias_we = 1'b1; bias_data = 6'd0;
    tick();
    bias_we = 1'b0;
    // New weight now in effect: acc = -8 + 7 = -1, t = 7
    start_run(8'hFF);
    wait_result("newweight", 6'h1C);
    accept("newweight", 6'h1C);

    // Negative saturation: acc = -5 - 248 = -253
    set_all(6'd31, 6'h3B, 2'b11);
    start_run(8'h00);
    exp_sat = 3;
    wait_result("negsat", 6'h03);
    accept("negsat", 6'h03);

    // -32 negates exactly: acc = -31 + 32 = 1, t = 9
    set_all(6'd0, 6'h21, 2'b10);
    w_we = 1'b1; w_addr = 3'd0; w_data = 6'h20;
    tick();
    w_we = 1'b0;
    out_ready = 1'b0;
    start_run(8'h00);
    wait_result("minw", 6'h26);

    // Backpressure: hold 5 cycles with start pulsed and spins toggling
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      spins = ~spins;
      tick();
      check("bp_valid", {31'd0, out_valid}, 1);
      check("bp_word", {26'd0, out_word}, 32'h26);
      check("bp_busy", {31'd0, busy}, 1);
    end
    start = 1'b0;
    accept("bp", 6'h26);

    // Subsequent start accepted: acc = -31 - 32 = -63
    start_run(8'h01);
    exp_sat = 4;
    wait_result("after_bp", 6'h02);
    accept("after_bp", 6'h02);

    // Reset mid-ACCUM at idx = 3
    start_run(8'hFF);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_sat = 0;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_valid", {31'd0, out_valid}, 0);
    check("midrst_word", {26'd0, out_word}, 32'h20);
    check_sat("midrst_sat");

    // Configuration cleared: any spins give a zero field
    start_run(8'hA5);
    wait_result("postrst", 6'h20);
    accept("postrst", 6'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
